// File: rtl/ema_channel_scheduler.sv
// Time-shared exponential moving average for NCH requesting channels.
// A round-robin arbiter feeds one alpha LUT lookup and one multiply-accumulate datapath.
module ema_channel_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req,
    input  logic [NCH*DW-1:0]        x_in,
    input  logic [NCH*8-1:0]         alpha_addr,
    output logic [NCH-1:0]           gnt,
    output logic [7:0]               lut_addr,
    input  logic [15:0]              lut_data,
    output logic [NCH*DW-1:0]        y_out,
    output logic                     done,
    output logic [$clog2(NCH)-1:0]   done_ch,
    output logic                     busy
);
    localparam int CW = $clog2(NCH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] MAC    = 2'd2;
    localparam logic [1:0] WRITE  = 2'd3;

    logic [1:0]           state_reg;
    logic [CW-1:0]        last_reg;
    logic [CW-1:0]        ch_reg;
    logic [7:0]           addr_reg;
    logic [DW-1:0]        x_reg;
    logic [5:0]           alpha_reg;
    logic signed [DW:0]   diff_reg;
    logic [NCH-1:0]       seeded_reg;
    logic [DW-1:0]        y_reg [NCH];

    logic [DW-1:0]        x_ch    [NCH];
    logic [7:0]           addr_ch [NCH];
    logic                 win_found;
    logic [CW-1:0]        win_idx;
    int                   cand;
    logic [DW-1:0]        y_cur;
    logic signed [DW+7:0] prod;
    logic [DW-1:0]        y_next;
    logic                 lut_unused;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign x_ch[gi]              = x_in[gi*DW +: DW];
            assign addr_ch[gi]           = alpha_addr[gi*8 +: 8];
            assign y_out[gi*DW +: DW]    = y_reg[gi];
        end
    endgenerate

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand = (int'(last_reg) + k) % NCH;
            if (!win_found && req[cand[CW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (!rst && state_reg == IDLE && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign y_cur      = y_reg[ch_reg];
    assign prod       = diff_reg * $signed({1'b0, alpha_reg});
    // Truncation to DW bits is exact: alpha <= 63/64 keeps the sum inside 0..2^DW-1.
    assign y_next     = y_cur + DW'(prod >>> 6);
    assign lut_addr   = addr_reg;
    assign busy       = !rst && state_reg != IDLE;
    assign done       = !rst && state_reg == WRITE;
    assign done_ch    = done ? ch_reg : '0;
    assign lut_unused = ^lut_data[15:6];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            last_reg   <= CW'(NCH - 1);
            ch_reg     <= '0;
            addr_reg   <= '0;
            x_reg      <= '0;
            alpha_reg  <= '0;
            diff_reg   <= '0;
            seeded_reg <= '0;
            for (int i = 0; i < NCH; i++) begin
                y_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        ch_reg    <= win_idx;
                        last_reg  <= win_idx;
                        x_reg     <= x_ch[win_idx];
                        addr_reg  <= addr_ch[win_idx];
                        state_reg <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    alpha_reg <= lut_data[5:0];
                    diff_reg  <= $signed({1'b0, x_reg}) - $signed({1'b0, y_cur});
                    state_reg <= MAC;
                end
                MAC: begin
                    // The write lands on the edge entering WRITE, so y_out and done appear together.
                    y_reg[ch_reg]      <= seeded_reg[ch_reg] ? y_next : x_reg;
                    seeded_reg[ch_reg] <= 1'b1;
                    state_reg          <= WRITE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ema_channel_scheduler.sv
// Bench for ema_channel_scheduler: per-cycle transaction-level model plus directed literal checks.
module tb_ema_channel_scheduler;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH-1:0]       req = '0;
    logic [NCH*DW-1:0]    x_in = '0;
    logic [NCH*8-1:0]     alpha_addr = '0;
    logic [NCH-1:0]       gnt;
    logic [7:0]           lut_addr;
    logic [15:0]          lut_data;
    logic [NCH*DW-1:0]    y_out;
    logic                 done;
    logic [1:0]           done_ch;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    ema_channel_scheduler #(.NCH(NCH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in), .alpha_addr(alpha_addr),
        .gnt(gnt), .lut_addr(lut_addr), .lut_data(lut_data), .y_out(y_out),
        .done(done), .done_ch(done_ch), .busy(busy)
    );

    assign lut_data = 16'(lut_addr >> 2);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a service occupies 4 cycles; the result is known at grant and shown 3 cycles later.
    int          ph = 0;
    int          m_last = NCH - 1;
    int          m_ch = 0;
    int          m_pend = 0;
    int          my [NCH];
    bit          ms [NCH];
    logic [7:0]  m_la = '0;
    bit          armed = 1'b0;

    always @(negedge clk) begin
        int w;
        int c;
        int xv;
        int av;
        logic [NCH-1:0]    eg;
        logic [NCH*DW-1:0] ey;
        w = -1;
        if (ph == 0) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last + k) % NCH;
                if (w < 0 && req[c]) w = c;
            end
        end
        eg = '0;
        if (!rst && w >= 0) eg[w] = 1'b1;
        if (armed) begin
            for (int i = 0; i < NCH; i++) ey[i*DW +: DW] = 16'(my[i]);
            check("gnt", 64'(gnt), 64'(eg));
            check("busy", 64'(busy), 64'(!rst && ph != 0));
            check("done", 64'(done), 64'(!rst && ph == 3));
            if (!rst && ph == 3) check("done_ch", 64'(done_ch), 64'(m_ch));
            check("lut_addr", 64'(lut_addr), 64'(m_la));
            check("y_out", 64'(y_out), 64'(ey));
        end
        if (rst) begin
            armed  = 1'b1;
            ph     = 0;
            m_last = NCH - 1;
            m_ch   = 0;
            m_la   = '0;
            for (int i = 0; i < NCH; i++) begin
                my[i] = 0;
                ms[i] = 1'b0;
            end
        end else begin
            case (ph)
                0: if (w >= 0) begin
                    xv     = int'(x_in[w*DW +: DW]);
                    av     = int'(alpha_addr[w*8 +: 8]) / 4;
                    m_ch   = w;
                    m_last = w;
                    m_la   = alpha_addr[w*8 +: 8];
                    m_pend = ms[w] ? my[w] + (((xv - my[w]) * av) >>> 6) : xv;
                    ph     = 1;
                end
                1: ph = 2;
                2: begin
                    my[m_ch] = m_pend;
                    ms[m_ch] = 1'b1;
                    ph = 3;
                end
                default: ph = 0;
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic serve(input int ch, input int xv, input int av, input bit chg);
        int n;
        @(posedge clk); #1;
        x_in[ch*DW +: DW]    = 16'(xv);
        alpha_addr[ch*8 +: 8] = 8'(av);
        req[ch] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[ch] && n < 20);
        check("gnt_seen", 64'(gnt[ch]), 64'd1);
        @(posedge clk); #1;
        req[ch] = 1'b0;
        if (chg) begin
            x_in[ch*DW +: DW]     = '0;
            alpha_addr[ch*8 +: 8] = '0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        check("latency", 64'(n), 64'd3);
        check("done_ch_lit", 64'(done_ch), 64'(ch));
        $display("txn ch=%0d x=%0d addr=%0d -> y=%0d", ch, xv, av, y_out[ch*DW +: DW]);
    endtask

    initial begin
        int order[$];
        int times[$];
        int exp_order[5];
        int cyc;
        int idx;
        int n;
        exp_order = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_y", 64'(y_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_lut", 64'(lut_addr), 64'd0);

        serve(0, 1000, 128, 1'b0);
        check("seed_y0", 64'(y_out[0 +: DW]), 64'd1000);
        serve(0, 2000, 128, 1'b1);
        check("half_y0", 64'(y_out[0 +: DW]), 64'd1500);
        serve(0, 0, 255, 1'b0);
        check("a63_y0", 64'(y_out[0 +: DW]), 64'd23);
        serve(1, 500, 128, 1'b0);
        check("seed_y1", 64'(y_out[DW +: DW]), 64'd500);
        serve(1, 9000, 2, 1'b0);
        check("a0_y1", 64'(y_out[DW +: DW]), 64'd500);

        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NCH; i++) begin
            x_in[i*DW +: DW]     = 16'(100 * (i + 1));
            alpha_addr[i*8 +: 8] = 8'd128;
        end
        req = '1;
        cyc = 0;
        while (order.size() < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0) begin
                idx = 0;
                for (int i = 0; i < NCH; i++) if (gnt[i]) idx = i;
                order.push_back(idx);
                times.push_back(cyc);
                $display("txn rr grant ch=%0d cycle=%0d", idx, cyc);
                @(posedge clk); #1;
                req[idx] = 1'b0;
                if (idx == 1) req[0] = 1'b1;
            end
        end
        check("rr_count", 64'(order.size()), 64'd5);
        for (int k = 0; k < order.size(); k++) begin
            check("rr_order", 64'(order[k]), 64'(exp_order[k]));
            if (k > 0) check("rr_spacing", 64'(times[k] - times[k-1]), 64'd4);
        end
        repeat (5) @(negedge clk);

        do_reset();
        @(posedge clk); #1;
        x_in[2*DW +: DW]     = 16'd700;
        alpha_addr[2*8 +: 8] = 8'd128;
        req[2] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[2] && n < 20);
        check("abort_gnt", 64'(gnt[2]), 64'd1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", 64'(n), 64'd0);
        check("abort_y2", 64'(y_out[2*DW +: DW]), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        $display("txn abort ch=2 y=%0d", y_out[2*DW +: DW]);
        serve(2, 800, 128, 1'b0);
        check("reseed_y2", 64'(y_out[2*DW +: DW]), 64'd800);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ema_channel_scheduler.md
EMA_CHANNEL_SCHEDULER -- requirements
Module: ema_channel_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels that share one alpha LUT and one EMA datapath.
REQ-002 Parameter DW, default 16: sample and filter-state width, unsigned.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NCH  per-channel update request; held high by the requester until granted.
REQ-006 x_in  input  NCH*DW  per-channel new sample; channel i occupies bits [i*DW +: DW].
REQ-007 alpha_addr  input  NCH*8  per-channel alpha LUT address; channel i occupies bits [i*8 +: 8].
REQ-008 gnt  output  NCH  one-hot, one-cycle grant; marks the cycle in which x_in and alpha_addr of that channel are captured.
REQ-009 lut_addr  output  8  address driven to the external combinational alpha LUT.
REQ-010 lut_data  input  16  LUT result, where lut_data = lut_addr>>2 (range 0..63); only bits [5:0] are used.
REQ-011 y_out  output  NCH*DW  registered per-channel filter state.
REQ-012 done  output  1  one-cycle pulse indicating that a channel's y_out was updated this cycle.
REQ-013 done_ch  output  log2(NCH)  index of the updated channel; valid only while done=1.
REQ-014 busy  output  1  high in every state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOOKUP, MAC and WRITE, with transitions IDLE->LOOKUP->MAC->WRITE->IDLE.
REQ-016 In IDLE with any req bit set, the block SHALL assert gnt for the round-robin winner and latch its x_in, alpha_addr and channel index, then move to LOOKUP.
REQ-017 In IDLE with req all zero, gnt SHALL be 0 and the state SHALL remain IDLE.
REQ-018 Round-robin: search starts at the channel after the last granted one, wrapping from NCH-1 to 0; after reset the search starts at channel 0.
REQ-019 The block SHALL evaluate req only in IDLE; requests raised in any other state wait, and gnt is never asserted outside IDLE.
REQ-020 lut_addr SHALL be driven from the latched address register in LOOKUP, and SHALL hold that register value in all other states.
REQ-021 LOOKUP: register alpha = lut_data[5:0] and diff = x - y[ch] as a signed DW+1 value.
REQ-022 MAC: register prod = diff*alpha as a signed DW+8 value, then apply an arithmetic right shift by 6 (floor).
REQ-023 WRITE: y[ch] <= y[ch] + prod_shifted; the result SHALL stay in 0..2^DW-1 because alpha <= 63/64, so no saturation logic is required.
REQ-024 Seeding: each channel has a seeded flag, cleared by reset; the first update after reset SHALL write y[ch] <= x and set the flag, ignoring alpha.
REQ-025 WRITE SHALL pulse done=1 with done_ch=ch and then return to IDLE.
REQ-026 Latency: gnt in cycle T results in done and the new y_out visible in cycle T+3.
REQ-027 Throughput: at most one update per 4 cycles; back-to-back requests are granted in the IDLE cycle that follows WRITE.
REQ-028 alpha_addr 0..3 gives alpha=0, so y SHALL be unchanged, but done SHALL still pulse.
REQ-029 If the requester changes x_in or alpha_addr after gnt, the operation in flight SHALL be unaffected, because values are used only from the latches.

Reset
REQ-030 While rst=1: state=IDLE, gnt=0, done=0, done_ch=0, busy=0, lut_addr=0, all y=0, all seeded flags=0, round-robin pointer set so channel 0 has highest priority.
REQ-031 rst asserted mid-operation SHALL abort the operation: no done pulse, and the next cycle after rst deasserts SHALL be IDLE with reset values.

Verification
REQ-032 Channel 0 unseeded, x=1000, addr=128 -> gnt[0] at T, done at T+3, y0=1000; then x=2000, addr=128 (alpha 32) -> y0=1500.
REQ-033 From y0=1500: x=0, addr=255 (alpha 63) -> diff*63=-94500, >>>6 gives -1477 -> y0=23.
REQ-034 Seeded y1=500: x=9000, addr=2 -> done pulses with done_ch=1, y1 stays 500.
REQ-035 After reset, req=4'b1111 held high -> grants to channels 0,1,2,3 at T, T+4, T+8, T+12; with req[0] re-raised during channel 1 service, channel 2 is granted before channel 0.
REQ-036 rst pulsed for one cycle while in MAC for channel 2 -> no done, y2=0, busy=0; the next request on channel 2 seeds it (y2=x).
REQ-037 x_in[0] changed to 0 the cycle after gnt[0] (y0=1000, x=2000, addr=128) -> y0=1500 regardless of the change.
